// File: rtl/sdp_bram_w64_r16_if.sv
// Bus bundle for sdp_bram_w64_r16: 64-bit write port A and 16-bit read port B.
// The master modport belongs to the producer/consumer logic. The slave modport belongs to the RAM.
interface sdp_bram_w64_r16_if #(
  parameter int WR_ADDR_WIDTH = 5,
  parameter int RD_DATA_WIDTH = 16,
  parameter int WR_DATA_WIDTH = 64
);
  localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH + 2;

  logic                     cea;   // write enable
  logic [WR_ADDR_WIDTH-1:0] ada;   // write word address
  logic [WR_DATA_WIDTH-1:0] din;   // write data
  logic                     ceb;   // read enable
  logic [RD_ADDR_WIDTH-1:0] adb;   // read halfword address
  logic [RD_DATA_WIDTH-1:0] dout;  // registered read data

  modport master (output cea, ada, din, ceb, adb, input dout);
  modport slave  (input cea, ada, din, ceb, adb, output dout);
endinterface

// File: rtl/sdp_bram_w64_r16.sv
// sdp_bram_w64_r16: simple dual-port RAM, 32 x 64-bit write side, 128 x 16-bit read side.
// Lanes are little-endian: adb = {word, lane}, and lane 0 is din[15:0].
// Reads return the old contents when the same word is written on the same edge.
// reset_n clears only the output register(s). The array is never cleared.
// Optional build macro SDPB_OUTREG_EN adds a second output register and gives 2-cycle read latency.
module sdp_bram_w64_r16 #(
  parameter int WR_ADDR_WIDTH = 5,
  parameter int RD_DATA_WIDTH = 16,
  parameter int WR_DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdp_bram_w64_r16_if.slave    bus
);
  localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH + 2;
  localparam int DEPTH         = 2 ** WR_ADDR_WIDTH;

  logic [WR_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [WR_ADDR_WIDTH-1:0] w_rd_word_addr;
  logic [1:0]               w_rd_lane;
  logic [WR_DATA_WIDTH-1:0] w_rd_word;
  logic [RD_DATA_WIDTH-1:0] w_rd_data;
  logic [RD_DATA_WIDTH-1:0] r_dout;

  assign w_rd_word_addr = bus.adb[RD_ADDR_WIDTH-1:2];
  assign w_rd_lane      = bus.adb[1:0];
  assign w_rd_word      = r_mem[w_rd_word_addr];

  // Select the addressed 16-bit lane of the read word (little-endian lane order)
  always_comb begin
    w_rd_data = {RD_DATA_WIDTH{1'b0}};
    case (w_rd_lane)
      2'd0:    w_rd_data = w_rd_word[RD_DATA_WIDTH*0 +: RD_DATA_WIDTH];
      2'd1:    w_rd_data = w_rd_word[RD_DATA_WIDTH*1 +: RD_DATA_WIDTH];
      2'd2:    w_rd_data = w_rd_word[RD_DATA_WIDTH*2 +: RD_DATA_WIDTH];
      2'd3:    w_rd_data = w_rd_word[RD_DATA_WIDTH*3 +: RD_DATA_WIDTH];
      default: w_rd_data = {RD_DATA_WIDTH{1'b0}};
    endcase
  end

  // Full-word write. There is no reset, so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (bus.cea) begin
      r_mem[bus.ada] <= bus.din;
    end
  end

  // Array read register. It samples pre-write contents, which gives read-before-write behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= {RD_DATA_WIDTH{1'b0}};
    end else if (bus.ceb) begin
      r_dout <= w_rd_data;
    end
  end

`ifdef SDPB_OUTREG_EN
  logic [RD_DATA_WIDTH-1:0] r_dout_pipe;

  // Second output stage. It advances together with the array register on ceb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout_pipe <= {RD_DATA_WIDTH{1'b0}};
    end else if (bus.ceb) begin
      r_dout_pipe <= r_dout;
    end
  end

  assign bus.dout = r_dout_pipe;
`else
  assign bus.dout = r_dout;
`endif

endmodule

// File: tb/tb_sdp_bram_w64_r16.sv
// Scoreboard bench for sdp_bram_w64_r16.
// The driver pushes expected read data together with the cycle in which it must appear.
// The monitor pops and compares entries on the falling edge.
module tb_sdp_bram_w64_r16;
`ifdef SDPB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    int          due;
    logic [15:0] exp;
    logic [6:0]  adr;
    logic [7:0]  tag;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] tag_cnt = 8'd0;
  sb_t  sb_q[$];
  sb_t  mon_e;

  sdp_bram_w64_r16_if bus ();

  sdp_bram_w64_r16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare dout against the oldest expectation when its cycle comes up
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      if (sb_q[0].due == cyc_cnt) begin
        mon_e = sb_q.pop_front();
        n_cmp = n_cmp + 1;
        if (bus.dout !== mon_e.exp) begin
          n_err = n_err + 1;
          $display("FAIL rd%0d adb=%0d: dout=%h expected=%h", mon_e.tag, mon_e.adr, bus.dout, mon_e.exp);
        end
      end else if (sb_q[0].due < cyc_cnt) begin
        mon_e = sb_q.pop_front();
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL rd%0d overdue: due=%0d now=%0d", mon_e.tag, mon_e.due, cyc_cnt);
      end
    end
  end

  task automatic check_now(input string nm, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (bus.dout !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: dout=%h expected=%h", nm, bus.dout, exp);
    end
  endtask

  task automatic step(input logic a_en, input logic [4:0] a_ad, input logic [63:0] a_d,
                      input logic b_en, input logic [6:0] b_ad,
                      input logic do_chk, input logic [15:0] exp);
    @(negedge clk);
    bus.cea = a_en;
    bus.ada = a_ad;
    bus.din = a_d;
    bus.ceb = b_en;
    bus.adb = b_ad;
    if (do_chk) begin
      sb_q.push_back('{due: cyc_cnt + LAT, exp: exp, adr: b_ad, tag: tag_cnt});
      tag_cnt = tag_cnt + 8'd1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    step(1'b1, a, d, 1'b0, 7'd0, 1'b0, 16'h0000);
  endtask

  task automatic rd(input logic [6:0] a, input logic [15:0] exp);
    step(1'b0, 5'd0, 64'd0, 1'b1, a, 1'b1, exp);
  endtask

  // Extra read cycles push the last result through any additional output stage
  task automatic flush(input logic [6:0] a, input logic [15:0] exp);
    repeat (LAT - 1) rd(a, exp);
  endtask

  // ceb low: dout must hold its previous value
  task automatic hold(input logic [15:0] exp);
    step(1'b0, 5'd0, 64'd0, 1'b0, 7'd127, 1'b1, exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL drain_timeout: pending=%0d expected=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    bus.cea = 1'b0; bus.ada = 5'd0; bus.din = 64'd0;
    bus.ceb = 1'b0; bus.adb = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_dout", 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    hold(16'h0000);

    // Basic lane mapping at word 0
    wr(5'd0, 64'h0004_0003_0002_0001);
    rd(7'd0, 16'h0001); rd(7'd1, 16'h0002); rd(7'd2, 16'h0003); rd(7'd3, 16'h0004);
    flush(7'd3, 16'h0004);

    // Top word and address boundary, then recheck word 0
    wr(5'd31, 64'hDDDD_CCCC_BBBB_AAAA);
    rd(7'd124, 16'hAAAA); rd(7'd125, 16'hBBBB); rd(7'd126, 16'hCCCC); rd(7'd127, 16'hDDDD);
    flush(7'd127, 16'hDDDD);
    for (int i = 0; i < 4; i++) rd(7'(i), 16'(i + 1));
    flush(7'd3, 16'h0004);

    // ceb low holds dout while adb changes
    rd(7'd1, 16'h0002); flush(7'd1, 16'h0002);
    hold(16'h0002); hold(16'h0002); hold(16'h0002);
    rd(7'd127, 16'hDDDD); flush(7'd127, 16'hDDDD);
    hold(16'hDDDD);
    drain();

    // Async reset between edges. A write issued during reset must still land.
    #1 reset_n = 1'b0;
    #1 check_now("async_reset", 16'h0000);
    bus.ceb = 1'b1; bus.adb = 7'd0;
    bus.cea = 1'b1; bus.ada = 5'd2; bus.din = 64'h8888_7777_6666_5555;
    @(posedge clk);
    #1 check_now("reset_blocks_read", 16'h0000);
    @(negedge clk);
    bus.cea = 1'b0; bus.ceb = 1'b0;
    reset_n = 1'b1;
    rd(7'd0, 16'h0001); flush(7'd0, 16'h0001);
    rd(7'd9, 16'h6666); flush(7'd9, 16'h6666);

    // Same-word read and write on one edge returns the old data
    step(1'b1, 5'd0, 64'h1111_1111_1111_1111, 1'b1, 7'd0, 1'b1, 16'h0001);
    rd(7'd0, 16'h1111); flush(7'd0, 16'h1111);

    // With cea low, nothing is written
    step(1'b0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd0, 1'b0, 16'h0000);
    rd(7'd0, 16'h1111); flush(7'd0, 16'h1111);

    // Independent ports in one cycle
    step(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 1'b1, 7'd126, 1'b1, 16'hCCCC);
    rd(7'd20, 16'hCDEF); rd(7'd23, 16'h0123); flush(7'd23, 16'h0123);
    hold(16'h0123);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
